// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared types and constants for the branch-update queue.
//   bp_upd_state_e : lifecycle of one queue entry (EMPTY -> PENDING -> RESOLVED)
//   bp_upd_entry_t : one entry as seen by the retire logic
//   BP_PC_W        : branch PC width
// -----------------------------------------------------------------------------
package bp_pkg;

    localparam int BP_PC_W = 64;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        PENDING  = 2'd1,
        RESOLVED = 2'd2
    } bp_upd_state_e;

    typedef struct packed {
        logic [BP_PC_W-1:0] pc;
        logic               pred;
        logic               taken;
        bp_upd_state_e      state;
    } bp_upd_entry_t;

endpackage : bp_pkg

// File: rtl/bp_update_queue.sv
// -----------------------------------------------------------------------------
// bp_update_queue
// Producer-side training queue for the branch predictor. Fetch allocates an
// entry per predicted branch, execute resolves entries by tag in any order,
// and resolved entries retire strictly in fetch order as one-cycle update
// pulses, with a mispredict flag when the actual direction differs from the
// prediction.
//
// Parameters
//   DEPTH  number of entries (power of two, >= 2)
//   TAG_W  derived tag width, $clog2(DEPTH)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   alloc_valid_i/ready_o      fetch allocation handshake (ready = not full)
//   alloc_pc_i, alloc_pred_taken_i  branch PC and predicted direction
//   alloc_tag_o                tag the next allocation receives (tail index)
//   resolve_valid_i/tag_i/taken_i   out-of-order outcome from execute
//   flush_i                    discard every entry, reset pointers
//   update_valid_o/pc_o/taken_o     registered training pulse, fetch order
//   mispredict_o               high with update_valid_o when taken != pred
//   count_o                    occupied entries
//   mispredict_cnt_o           (BP_UPDQ_STATS_EN only) saturating count of
//                              mispredicted retires; survives flush
//
// Build option: define BP_UPDQ_STATS_EN to add the mispredict counter port.
// -----------------------------------------------------------------------------
module bp_update_queue
    import bp_pkg::*;
#(
    parameter int  DEPTH = 16,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               alloc_valid_i,
    output logic               alloc_ready_o,
    input  logic [63:0]        alloc_pc_i,
    input  logic               alloc_pred_taken_i,
    output logic [TAG_W-1:0]   alloc_tag_o,

    input  logic               resolve_valid_i,
    input  logic [TAG_W-1:0]   resolve_tag_i,
    input  logic               resolve_taken_i,

    input  logic               flush_i,

    output logic               update_valid_o,
    output logic [63:0]        update_pc_o,
    output logic               update_taken_o,
    output logic               mispredict_o,
`ifdef BP_UPDQ_STATS_EN
    output logic [31:0]        mispredict_cnt_o,
`endif
    output logic [TAG_W:0]     count_o
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [TAG_W:0]     head_q, tail_q;
    logic [TAG_W-1:0]   head_idx, tail_idx;

    bp_upd_state_e      state_q [DEPTH];
    logic [BP_PC_W-1:0] pc_q    [DEPTH];
    logic               pred_q  [DEPTH];
    logic               taken_q [DEPTH];

    bp_upd_entry_t      head_entry;
    logic               full;
    logic               alloc_fire;
    logic               resolve_fire;
    logic               retire_fire;

    assign head_idx = head_q[TAG_W-1:0];
    assign tail_idx = tail_q[TAG_W-1:0];

    assign full          = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);
    assign alloc_ready_o = !full;
    assign alloc_tag_o   = tail_idx;
    assign count_o       = tail_q - head_q;

    assign head_entry = '{pc:    pc_q[head_idx],
                          pred:  pred_q[head_idx],
                          taken: taken_q[head_idx],
                          state: state_q[head_idx]};

    // Readiness comes from registered pointers only, so a retire in this cycle
    // cannot make room for an allocation in the same cycle.
    assign alloc_fire   = alloc_valid_i && !full;
    // Resolves aimed at EMPTY or already-RESOLVED entries are dropped.
    assign resolve_fire = resolve_valid_i && (state_q[resolve_tag_i] == PENDING);
    // Retire looks at registered state, so a head resolved this cycle waits one.
    assign retire_fire  = (head_entry.state == RESOLVED);

    // Alloc hits an EMPTY tail entry, resolve a PENDING one and retire the
    // RESOLVED head, so the three writes never target the same entry.
    // NOTE: all sequential state uses non-blocking assignments so every
    // register sees pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) state_q[i] <= EMPTY;
        end else if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) state_q[i] <= EMPTY;
        end else begin
            if (alloc_fire)   state_q[tail_idx]      <= PENDING;
            if (resolve_fire) state_q[resolve_tag_i] <= RESOLVED;
            if (retire_fire)  state_q[head_idx]      <= EMPTY;
        end
    end

    // NOTE: the payload arrays have no reset; an entry's payload is only ever
    // read once its state says it was written, so only state needs a reset.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            pc_q[tail_idx]   <= alloc_pc_i;
            pred_q[tail_idx] <= alloc_pred_taken_i;
        end
        if (resolve_fire) begin
            taken_q[resolve_tag_i] <= resolve_taken_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else if (flush_i) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (alloc_fire)  tail_q <= tail_q + 1'b1;
            if (retire_fire) head_q <= head_q + 1'b1;
        end
    end

    // Training port. PC/direction hold their last value between pulses;
    // mispredict is qualified so it is only ever high alongside valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            update_valid_o <= 1'b0;
            update_pc_o    <= '0;
            update_taken_o <= 1'b0;
            mispredict_o   <= 1'b0;
        end else if (flush_i) begin
            update_valid_o <= 1'b0;
            mispredict_o   <= 1'b0;
        end else begin
            update_valid_o <= retire_fire;
            mispredict_o   <= retire_fire && (head_entry.taken ^ head_entry.pred);
            if (retire_fire) begin
                update_pc_o    <= head_entry.pc;
                update_taken_o <= head_entry.taken;
            end
        end
    end

`ifdef BP_UPDQ_STATS_EN
    // Counts pulses already presented on the port, so a flush arriving after a
    // mispredicted retire never loses it; deliberately not cleared by flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict_cnt_o <= '0;
        end else if (update_valid_o && mispredict_o && (mispredict_cnt_o != 32'hFFFF_FFFF)) begin
            mispredict_cnt_o <= mispredict_cnt_o + 32'd1;
        end
    end
`endif

endmodule : bp_update_queue
